// File: rtl/ler_palavra_pkg.sv
// Shared frame-buffer definitions for the word reader and writer.
// Holds the default geometry and the reader state encoding.
package ler_palavra_pkg;

   localparam int LP_WORD_BITS  = 32;
   localparam int LP_ADDR_WIDTH = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIM   = 2'd3
   } estado_t;

endpackage

// File: rtl/ler_palavra.sv
// Reads WORD_BITS consecutive one-bit pixels from the frame buffer
// and assembles them into a word, bit i from address base + i.
module ler_palavra
   import ler_palavra_pkg::*;
#(
   parameter int WORD_BITS    = LP_WORD_BITS,
   parameter int ADDR_WIDTH   = LP_ADDR_WIDTH,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] endereco_base,
   output logic [ADDR_WIDTH-1:0] rdaddress,
   input  logic                  q,
   output logic [WORD_BITS-1:0]  dados_out,
   output logic                  busy,
   output logic                  done
);

   localparam int IW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORD_BITS - 1);

   estado_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]   rdaddress_q, rdaddress_d;
   logic [IW-1:0]           cnt_q, cnt_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [WORD_BITS-1:0]    dados_q, dados_d;
   logic [WORD_BITS-1:0]    shadow_q, shadow_d;
   logic [READ_LATENCY-1:0] dl_v_q, dl_v_d;
   logic [IW-1:0]           dl_i_q [READ_LATENCY];
   logic [IW-1:0]           dl_i_d [READ_LATENCY];
   logic                    issue;
   logic                    cap;
   logic [IW-1:0]           cap_idx;

   // Tail of the delay line: bit index whose data is on q now
   assign cap     = dl_v_q[READ_LATENCY-1];
   assign cap_idx = dl_i_q[READ_LATENCY-1];

   always_comb begin
      state_d     = state_q;
      rdaddress_d = rdaddress_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      dados_d     = dados_q;
      shadow_d    = shadow_q;
      issue       = 1'b0;
      if (cap) begin
         shadow_d[cap_idx] = q;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = ISSUE;
               rdaddress_d = endereco_base;
               cnt_d       = '0;
               busy_d      = 1'b1;
               shadow_d    = '0;
            end
         end
         ISSUE: begin
            issue = 1'b1;
            if (cnt_q == LAST) begin
               state_d = DRAIN;
            end else begin
               cnt_d       = cnt_q + IW'(1);
               rdaddress_d = rdaddress_q + ADDR_WIDTH'(1);
            end
         end
         DRAIN: begin
            // Leave as the last bit lands, including it in the copy
            if (cap && cap_idx == LAST) begin
               state_d = FIM;
               done_d  = 1'b1;
               dados_d = shadow_d;
            end
         end
         FIM: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      dl_v_d[0] = issue;
      dl_i_d[0] = cnt_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
         dl_v_d[i] = dl_v_q[i-1];
         dl_i_d[i] = dl_i_q[i-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         rdaddress_q <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dados_q     <= '0;
         shadow_q    <= '0;
         dl_v_q      <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            dl_i_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         rdaddress_q <= rdaddress_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dados_q     <= dados_d;
         shadow_q    <= shadow_d;
         dl_v_q      <= dl_v_d;
         for (int i = 0; i < READ_LATENCY; i++) begin
            dl_i_q[i] <= dl_i_d[i];
         end
      end
   end

   assign rdaddress = rdaddress_q;
   assign dados_out = dados_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
